// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control unit: sequences fetch, decode, execute, memory and
// write-back, drives the datapath strobes, and tracks retirement and traps.
module multicycle_control #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic                  instr_valid,
  input  logic                  Zero,
  output logic                  IRWrite,
  output logic                  PCWrite,
  output logic                  PCSrc,
  output logic                  RegWrite,
  output logic                  MemWrite,
  output logic                  ALUSrc,
  output logic                  JumpSrc,
  output logic [1:0]            ResultSrc,
  output logic [2:0]            ALUControl,
  output logic [3:0]            state,
  output logic                  instr_done,
  output logic [DATA_WIDTH-1:0] retired,
  output logic                  illegal
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_EXEC_R  = 4'd2;
  localparam logic [3:0] S_EXEC_I  = 4'd3;
  localparam logic [3:0] S_MEM_ADR = 4'd4;
  localparam logic [3:0] S_MEM_RD  = 4'd5;
  localparam logic [3:0] S_MEM_WB  = 4'd6;
  localparam logic [3:0] S_MEM_WR  = 4'd7;
  localparam logic [3:0] S_ALU_WB  = 4'd8;
  localparam logic [3:0] S_BRANCH  = 4'd9;
  localparam logic [3:0] S_JUMP    = 4'd10;
  localparam logic [3:0] S_TRAP    = 4'd11;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  logic [3:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic [DATA_WIDTH-1:0] retired_q, retired_d;
  logic                  illegal_q, illegal_d;

  logic [6:0] opcode_s;
  logic [2:0] funct3_s;
  logic [6:0] funct7_s;
  logic       alu_legal_s;
  logic [2:0] alu_ctrl_s;
  logic [3:0] target_s;
  logic       unused_s;

  // Returns {legal, ALUControl}; R-type checks funct7 on every funct3, I-type only on shifts.
  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic [6:0] f7,
                                            input logic is_r);
    logic       ok;
    logic [2:0] ctl;
    ok  = 1'b1;
    ctl = ALU_ADD;
    case (f3)
      3'b000: begin
        if (is_r && (f7 == F7_ALT)) begin
          ctl = ALU_SUB;
        end else begin
          ctl = ALU_ADD;
          ok  = !is_r || (f7 == F7_ZERO);
        end
      end
      3'b001: begin
        ctl = ALU_SLL;
        ok  = (f7 == F7_ZERO);
      end
      3'b010: begin
        ctl = ALU_SLT;
        ok  = !is_r || (f7 == F7_ZERO);
      end
      3'b100: begin
        ctl = ALU_XOR;
        ok  = !is_r || (f7 == F7_ZERO);
      end
      3'b101: begin
        ctl = ALU_SRL;
        ok  = (f7 == F7_ZERO);
      end
      3'b110: begin
        ctl = ALU_OR;
        ok  = !is_r || (f7 == F7_ZERO);
      end
      3'b111: begin
        ctl = ALU_AND;
        ok  = !is_r || (f7 == F7_ZERO);
      end
      default: begin
        ctl = ALU_ADD;
        ok  = 1'b0;
      end
    endcase
    return {ok, ctl};
  endfunction

  assign opcode_s = ir_q[6:0];
  assign funct3_s = ir_q[14:12];
  assign funct7_s = ir_q[31:25];
  assign unused_s = ^{ir_q[24:15], ir_q[11:7]};
  assign {alu_legal_s, alu_ctrl_s} = alu_decode(funct3_s, funct7_s, opcode_s == OP_R);

  // Decode dispatch: first execute-phase state for the held instruction, TRAP otherwise.
  always_comb begin
    target_s = S_TRAP;
    case (opcode_s)
      OP_R: begin
        if (alu_legal_s) target_s = S_EXEC_R;
        else             target_s = S_TRAP;
      end
      OP_IMM: begin
        if (alu_legal_s) target_s = S_EXEC_I;
        else             target_s = S_TRAP;
      end
      OP_LOAD, OP_STORE: begin
        if (funct3_s == 3'b010) target_s = S_MEM_ADR;
        else                    target_s = S_TRAP;
      end
      OP_BRANCH: begin
        if (funct3_s[2:1] == 2'b00) target_s = S_BRANCH;
        else                        target_s = S_TRAP;
      end
      OP_JAL: target_s = S_JUMP;
      OP_JALR: begin
        if (funct3_s == 3'b000) target_s = S_JUMP;
        else                    target_s = S_TRAP;
      end
      default: target_s = S_TRAP;
    endcase
  end

  // Next-state sequencing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (instr_valid) state_d = S_DECODE;
        else             state_d = S_FETCH;
      end
      S_DECODE:           state_d = target_s;
      S_EXEC_R, S_EXEC_I: state_d = S_ALU_WB;
      S_MEM_ADR: begin
        if (opcode_s == OP_LOAD) state_d = S_MEM_RD;
        else                     state_d = S_MEM_WR;
      end
      S_MEM_RD:           state_d = S_MEM_WB;
      S_MEM_WB, S_MEM_WR, S_ALU_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_TRAP:             state_d = S_TRAP;
      default:            state_d = S_TRAP;
    endcase
  end

  // Datapath strobes; reset suppresses them so an abandoned instruction writes nothing.
  always_comb begin
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    PCSrc      = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    ALUSrc     = 1'b0;
    JumpSrc    = 1'b0;
    ResultSrc  = RES_ALU;
    ALUControl = ALU_ADD;
    instr_done = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: IRWrite = instr_valid;
        S_EXEC_R: begin
          ALUSrc     = 1'b0;
          ALUControl = alu_ctrl_s;
        end
        S_EXEC_I: begin
          ALUSrc     = 1'b1;
          ALUControl = alu_ctrl_s;
        end
        S_ALU_WB: begin
          ALUSrc     = (opcode_s == OP_IMM);
          ALUControl = alu_ctrl_s;
          RegWrite   = 1'b1;
          ResultSrc  = RES_ALU;
          PCWrite    = 1'b1;
          instr_done = 1'b1;
        end
        S_MEM_ADR, S_MEM_RD: ALUSrc = 1'b1;
        S_MEM_WB: begin
          ALUSrc     = 1'b1;
          RegWrite   = 1'b1;
          ResultSrc  = RES_MEM;
          PCWrite    = 1'b1;
          instr_done = 1'b1;
        end
        S_MEM_WR: begin
          ALUSrc     = 1'b1;
          MemWrite   = 1'b1;
          PCWrite    = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          ALUControl = ALU_SUB;
          PCWrite    = 1'b1;
          PCSrc      = funct3_s[0] ? !Zero : Zero;
          instr_done = 1'b1;
        end
        S_JUMP: begin
          RegWrite   = 1'b1;
          ResultSrc  = RES_PC4;
          PCWrite    = 1'b1;
          PCSrc      = 1'b1;
          JumpSrc    = (opcode_s == OP_JALR);
          instr_done = 1'b1;
        end
        default: instr_done = 1'b0;
      endcase
    end else begin
      instr_done = 1'b0;
    end
  end

  // Next values of the instruction register, retire counter and trap flag.
  always_comb begin
    if (IRWrite) ir_d = instr;
    else         ir_d = ir_q;
    retired_d = retired_q + {{(DATA_WIDTH-1){1'b0}}, instr_done};
    illegal_d = illegal_q | (state_d == S_TRAP);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      ir_q      <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  assign state   = state_q;
  assign retired = retired_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: an instruction-level model expands each word
// into its expected per-cycle trace, checked every cycle by one compare process.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic        Zero;
  logic        IRWrite, PCWrite, PCSrc, RegWrite, MemWrite, ALUSrc, JumpSrc;
  logic [1:0]  ResultSrc;
  logic [2:0]  ALUControl;
  logic [3:0]  state;
  logic        instr_done;
  logic [31:0] retired;
  logic        illegal;

  multicycle_control #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .Zero(Zero),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .ALUSrc(ALUSrc), .JumpSrc(JumpSrc), .ResultSrc(ResultSrc),
    .ALUControl(ALUControl), .state(state), .instr_done(instr_done),
    .retired(retired), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  st;
    logic        irw, pcw, pcsrc, regw, memw, alusrc, jsrc;
    logic [1:0]  res;
    logic [2:0]  ctl;
    logic        done;
    logic [31:0] ret;
    logic        ill;
  } obs_t;

  localparam int NTRAP = 10;
  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BR = 4, K_JMP = 5, K_ILL = 6;

  // funct3 -> ALU operation; bit 3 marks a funct3 with no ALU meaning.
  logic [3:0] alu_map [8] = '{4'h0, 4'h6, 4'h5, 4'h8, 4'h4, 4'h7, 4'h3, 4'h2};

  obs_t        exp_q[$];
  string       name_q[$];
  obs_t        plan_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] m_ret;
  logic        m_ill;

  function automatic obs_t blank(input logic [3:0] st);
    obs_t e;
    e     = '0;
    e.st  = st;
    e.ret = m_ret;
    e.ill = m_ill;
    return e;
  endfunction

  function automatic int classify(input logic [31:0] w);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    int k;
    op = w[6:0]; f3 = w[14:12]; f7 = w[31:25]; k = K_ILL;
    if (op == 7'b0110011 && !alu_map[f3][3] && (f7 == 7'h00 || (f3 == 3'd0 && f7 == 7'h20))) k = K_R;
    else if (op == 7'b0010011 && !alu_map[f3][3] && (f7 == 7'h00 || (f3 != 3'd1 && f3 != 3'd5))) k = K_I;
    else if (op == 7'b0000011 && f3 == 3'd2) k = K_LW;
    else if (op == 7'b0100011 && f3 == 3'd2) k = K_SW;
    else if (op == 7'b1100011 && f3 < 3'd2) k = K_BR;
    else if (op == 7'b1101111 || (op == 7'b1100111 && f3 == 3'd0)) k = K_JMP;
    return k;
  endfunction

  task automatic push_retire(input obs_t e);
    plan_q.push_back(e);
    m_ret = m_ret + 32'd1;
  endtask

  task automatic build(input logic [31:0] w, input logic z);
    obs_t e;
    int k;
    logic [2:0] ctl;
    k   = classify(w);
    ctl = (w[6:0] == 7'b0110011 && w[30]) ? 3'b001 : alu_map[w[14:12]][2:0];
    plan_q.delete();
    e = blank(4'd0); e.irw = 1'b1; plan_q.push_back(e);
    plan_q.push_back(blank(4'd1));
    case (k)
      K_R, K_I: begin
        e = blank((k == K_R) ? 4'd2 : 4'd3); e.alusrc = (k == K_I); e.ctl = ctl;
        plan_q.push_back(e);
        e.st = 4'd8; e.regw = 1'b1; e.pcw = 1'b1; e.done = 1'b1; push_retire(e);
      end
      K_LW: begin
        e = blank(4'd4); e.alusrc = 1'b1; plan_q.push_back(e);
        e.st = 4'd5; plan_q.push_back(e);
        e.st = 4'd6; e.regw = 1'b1; e.res = 2'b01; e.pcw = 1'b1; e.done = 1'b1; push_retire(e);
      end
      K_SW: begin
        e = blank(4'd4); e.alusrc = 1'b1; plan_q.push_back(e);
        e.st = 4'd7; e.memw = 1'b1; e.pcw = 1'b1; e.done = 1'b1; push_retire(e);
      end
      K_BR: begin
        e = blank(4'd9); e.ctl = 3'b001; e.pcw = 1'b1; e.pcsrc = w[12] ? !z : z; e.done = 1'b1;
        push_retire(e);
      end
      K_JMP: begin
        e = blank(4'd10); e.regw = 1'b1; e.res = 2'b10; e.pcw = 1'b1; e.pcsrc = 1'b1;
        e.jsrc = (w[6:0] == 7'b1100111); e.done = 1'b1; push_retire(e);
      end
      default: begin
        m_ill = 1'b1;
        repeat (NTRAP) plan_q.push_back(blank(4'd11));
      end
    endcase
  endtask

  function automatic obs_t sample();
    obs_t a;
    a.st = state; a.irw = IRWrite; a.pcw = PCWrite; a.pcsrc = PCSrc; a.regw = RegWrite;
    a.memw = MemWrite; a.alusrc = ALUSrc; a.jsrc = JumpSrc; a.res = ResultSrc;
    a.ctl = ALUControl; a.done = instr_done; a.ret = retired; a.ill = illegal;
    return a;
  endfunction

  // Per-cycle comparison of DUT outputs against the model trace.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t e, a;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = sample();
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s state=%0d got=%h want=%h", n, a.st, a, e);
      end
    end
  end

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [31:0] w, input logic z, input string nm, input int lim);
    build(w, z);
    for (int i = 0; i < plan_q.size(); i++) begin
      if (lim < 0 || i < lim) begin
        instr = w; instr_valid = (i == 0); Zero = z;
        exp_q.push_back(plan_q[i]);
        name_q.push_back($sformatf("%s[%0d]", nm, i));
        step();
      end
    end
    instr_valid = 1'b0;
  endtask

  task automatic idle_peek(input string nm);
    instr_valid = 1'b0;
    exp_q.push_back(blank(4'd0));
    name_q.push_back(nm);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; instr_valid = 1'b0;
    repeat (n) step();
    rst = 1'b0; m_ret = 32'd0; m_ill = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; instr = 32'd0; instr_valid = 1'b0; Zero = 1'b0;
    m_ret = 32'd0; m_ill = 1'b0;
    do_reset(2);
    idle_peek("reset_idle");
    lit("rst_state", state, 32'd0);
    lit("rst_retired", retired, 32'd0);
    lit("rst_illegal", illegal, 32'd0);
    lit("rst_strobes", {IRWrite, PCWrite, RegWrite, MemWrite, ALUSrc, JumpSrc,
                        ResultSrc, ALUControl, instr_done}, 32'd0);
    step();

    run(32'h002081B3, 1'b0, "add", -1);
    lit("add_len", plan_q.size(), 32'd4);
    lit("add_states", {plan_q[0].st, plan_q[1].st, plan_q[2].st, plan_q[3].st}, 32'h0128);
    lit("add_wb", {plan_q[3].regw, plan_q[3].res, plan_q[3].ctl, plan_q[3].pcw,
                   plan_q[3].pcsrc, plan_q[3].done}, 32'h105);
    idle_peek("add_after");
    lit("add_retired", retired, 32'd1);
    step();

    run(32'h402081B3, 1'b0, "sub", -1);
    lit("sub_ctl", plan_q[2].ctl, 32'd1);
    run(32'h00500093, 1'b0, "addi", -1);
    run(32'h0010D093, 1'b0, "srli", -1);
    lit("srli_wb", {plan_q[3].alusrc, plan_q[3].ctl}, 32'hF);
    run(32'h0020E1B3, 1'b0, "or", -1);
    run(32'h0020A1B3, 1'b0, "slt", -1);

    run(32'h0080A283, 1'b0, "lw", -1);
    lit("lw_states", {plan_q[0].st, plan_q[1].st, plan_q[2].st, plan_q[3].st, plan_q[4].st}, 32'h01456);
    lit("lw_wb", {plan_q[4].regw, plan_q[4].res}, 32'h5);
    run(32'h0050A423, 1'b0, "sw", -1);
    lit("sw_states", {plan_q[0].st, plan_q[1].st, plan_q[2].st, plan_q[3].st}, 32'h0147);
    lit("sw_memw", {plan_q[0].memw, plan_q[1].memw, plan_q[2].memw, plan_q[3].memw}, 32'h1);

    run(32'h00208463, 1'b1, "beq_z1", -1);
    lit("beq_z1_pcsrc", plan_q[2].pcsrc, 32'd1);
    run(32'h00208463, 1'b0, "beq_z0", -1);
    lit("beq_z0_pcsrc", plan_q[2].pcsrc, 32'd0);
    run(32'h00209463, 1'b1, "bne_z1", -1);
    lit("bne_z1_pcsrc", plan_q[2].pcsrc, 32'd0);
    run(32'h00209463, 1'b0, "bne_z0", -1);
    lit("bne_z0_pcsrc", plan_q[2].pcsrc, 32'd1);

    run(32'h000280E7, 1'b0, "jalr", -1);
    lit("jalr_pin", {plan_q[2].regw, plan_q[2].res, plan_q[2].jsrc, plan_q[2].pcsrc}, 32'h1B);
    run(32'h008000EF, 1'b0, "jal", -1);
    lit("jal_pin", {plan_q[2].regw, plan_q[2].res, plan_q[2].jsrc, plan_q[2].pcsrc}, 32'h19);
    idle_peek("count_idle");
    lit("retired_14", retired, 32'd14);
    step();

    run(32'h0050A423, 1'b0, "sw_abort", 3);
    rst = 1'b1;
    @(negedge clk);
    lit("abort_in_memwr", state, 32'd7);
    step();
    rst = 1'b0; m_ret = 32'd0; m_ill = 1'b0;
    @(negedge clk);
    lit("abort_state", state, 32'd0);
    lit("abort_memwrite", MemWrite, 32'd0);
    lit("abort_retired", retired, 32'd0);
    lit("abort_done", instr_done, 32'd0);
    step();

    repeat (2) begin
      idle_peek("fetch_wait");
      step();
    end
    idle_peek("fetch_wait_last");
    lit("wait_irwrite", IRWrite, 32'd0);
    lit("wait_state", state, 32'd0);
    step();

    run(32'hFFFFFFFF, 1'b0, "trap", -1);
    @(negedge clk);
    lit("trap_state", state, 32'd11);
    lit("trap_illegal", illegal, 32'd1);
    step();
    do_reset(1);
    idle_peek("trap_cleared");
    lit("trap_rst_state", state, 32'd0);
    lit("trap_rst_illegal", illegal, 32'd0);
    step();

    run(32'h00008283, 1'b0, "lb_trap", -1);
    lit("lb_trap_pin", plan_q[plan_q.size()-1].st, 32'd11);
    do_reset(1);
    run(32'h4020F1B3, 1'b0, "and_f7_trap", -1);
    do_reset(1);
    run(32'h40109093, 1'b0, "slli_f7_trap", -1);
    do_reset(1);
    run(32'h002081B3, 1'b0, "add_again", -1);
    idle_peek("final_idle");
    lit("final_retired", retired, 32'd1);
    step();

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle control unit for the RV32I datapath: sequences each instruction through fetch, decode, execute, memory and write-back states and drives the datapath's control strobes (RegWrite, ALUSrc, MemWrite, ResultSrc, JumpSrc, ALUControl) plus PC and instruction-register enables. It holds its own copy of the fetched instruction and consumes the ALU Zero flag. It also reports retirement, a retired-instruction count, and a sticky illegal-instruction trap.

## Interface
- DATA_WIDTH, 32, instruction width and retired-counter width
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- instr  input  DATA_WIDTH  instruction word from instruction memory
- instr_valid  input  1  instr is valid this cycle
- Zero  input  1  ALU zero flag
- IRWrite  output  1  instruction-register load (datapath copy)
- PCWrite  output  1  PC update enable
- PCSrc  output  1  0: PC+4, 1: PC target
- RegWrite / MemWrite / ALUSrc / JumpSrc  output  1 each  datapath strobes
- ResultSrc  output  2  00 ALU, 01 memory, 10 PC+4
- ALUControl  output  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SLL, 111 SRL
- state  output  4  current FSM state
- instr_done  output  1  one-cycle pulse in each terminal state
- retired  output  DATA_WIDTH  retired-instruction count
- illegal  output  1  sticky trap flag

## Operation
- States: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADR=4, MEM_RD=5, MEM_WB=6, MEM_WR=7, ALU_WB=8, BRANCH=9, JUMP=10, TRAP=11.
- Internal IR loads `instr` when state=FETCH and instr_valid=1. IRWrite equals that condition. All decoding uses the internal IR.
- FETCH: wait while instr_valid=0, then go to DECODE.
- DECODE routes by opcode:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 or 0100011 → MEM_ADR
  - 1100011 → BRANCH
  - 1101111 or 1100111 → JUMP
  - anything else, or an illegal funct field → TRAP
- Legal funct fields:
  - lw/sw: f3=010 only.
  - Branches: f3 000 (beq) or 001 (bne) only.
  - jalr: f3=000 only.
  - R-type ALUControl by f3: 000 ADD (f7=0000000) or SUB (f7=0100000); 111 AND; 110 OR; 100 XOR; 010 SLT; 001 SLL; 101 SRL. For every f3 other than 000, f7 must be 0000000.
  - I-ALU: same f3 map, except 000 is always ADD and f7 is checked only for 001 and 101 (must be 0000000).
- Per-state outputs. Any strobe not listed is 0; ALUControl is 000 unless stated.
  - EXEC_R: ALUSrc=0, ALUControl decoded. Next ALU_WB.
  - EXEC_I: ALUSrc=1, ALUControl decoded. Next ALU_WB.
  - ALU_WB: same ALUSrc/ALUControl as the preceding EXEC state, plus RegWrite=1, ResultSrc=00, PCWrite=1, PCSrc=0.
  - MEM_ADR: ALUSrc=1, ADD. Next MEM_RD for lw, MEM_WR for sw.
  - MEM_RD: ALUSrc=1, ADD. Next MEM_WB.
  - MEM_WB: ALUSrc=1, ADD, RegWrite=1, ResultSrc=01, PCWrite=1, PCSrc=0.
  - MEM_WR: ALUSrc=1, ADD, MemWrite=1, PCWrite=1, PCSrc=0.
  - BRANCH: ALUSrc=0, SUB, PCWrite=1. PCSrc=Zero for beq, !Zero for bne.
  - JUMP: RegWrite=1, ResultSrc=10, PCWrite=1, PCSrc=1. JumpSrc=1 for jalr, 0 for jal.
  - TRAP: all strobes 0, illegal=1. Stays in TRAP until rst.
- ALU_WB, MEM_WB, MEM_WR, BRANCH and JUMP are terminal states: each asserts instr_done and returns to FETCH.
- retired increments on every instr_done cycle. It wraps from 2^DATA_WIDTH-1 to 0.

## Timing
- Reset values: state=FETCH, internal IR=0, retired=0, illegal=0. All strobes are 0 in the cycle following reset.
- rst has priority in any state, including mid-instruction and TRAP. The instruction in flight is abandoned with no further RegWrite, MemWrite or PCWrite.
- Outputs are combinational from state and IR. The only Zero-dependent output is PCSrc in BRANCH (same cycle).
- Cycle counts from accepted fetch to retire, inclusive:
  - R-type / I-ALU: 4
  - lw: 5
  - sw: 4
  - branch: 3
  - jal / jalr: 3
- Each strobe is asserted for at most one cycle per instruction. The exception is ALUSrc/ALUControl, which are held across consecutive states.

## Test plan
- rst, then add x3,x1,x2 (0x002081B3) with instr_valid=1 → states 0,1,2,8. In state 8: RegWrite=1, ResultSrc=00, ALUControl=000, PCWrite=1, PCSrc=0, instr_done=1. Then retired=1.
- lw x5,8(x1) (0x0080A283) → states 0,1,4,5,6; in state 6 RegWrite=1, ResultSrc=01. Then sw x5,8(x1) (0x0050A423) → states 0,1,4,7; MemWrite=1 only in state 7.
- beq 0x00208463 with Zero=1 → PCSrc=1, with Zero=0 → PCSrc=0. bne 0x00209463 → PCSrc inverted relative to beq.
- jalr x1,0(x5) (0x000280E7) → in state 10: RegWrite=1, ResultSrc=10, JumpSrc=1, PCSrc=1. jal x1,8 (0x008000EF) → same but JumpSrc=0.
- Hold instr_valid=0 for 3 cycles in FETCH → state stays 0, IRWrite=0. Then 0xFFFFFFFF → state 11, illegal=1, which holds for 10 cycles. Then rst → state 0, illegal=0.
- Assert rst during state 7 → next cycle state=0, MemWrite=0, retired=0, and no instr_done pulse.
